// File: rtl/aes_sub_bytes_engine.sv
// Multi-cycle AES SubBytes: LANES shared S-box lanes walk the state group by group.
// Define AES_SBOX_INV_EN to add the inverse S-box per lane, selected by in_inv.
module aes_sub_bytes_engine #(
    parameter int NBYTES = 16,
    parameter int LANES  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] in_data,
    input  logic                in_inv,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] out_data,
    output logic                busy
);

    localparam int NGROUPS = NBYTES / LANES;
    localparam int CW = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(NGROUPS - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [0:255][7:0] SBOX_FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

`ifdef AES_SBOX_INV_EN
    localparam logic [0:255][7:0] SBOX_INV = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };
    logic mode_q;
`else
    logic unused_inv;
    assign unused_inv = in_inv;
`endif

    logic [1:0]          st_q;
    logic [CW-1:0]       cnt_q;
    logic [8*NBYTES-1:0] data_q;
    logic [8*NBYTES-1:0] data_d;
    logic [7:0]          lane_in  [LANES];
    logic [7:0]          lane_out [LANES];
    logic                is_busy;
    logic                is_done;

    // Encoding 2'd3 is never entered; it falls through to idle behaviour.
    assign is_busy   = (st_q == BUSY);
    assign is_done   = (st_q == DONE);
    assign in_ready  = !is_busy && !is_done;
    assign out_valid = is_done;
    assign busy      = is_busy;
    assign out_data  = data_q;

    // Route the current group's bytes to the lanes and look them up.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = '0;
            for (int g = 0; g < NGROUPS; g++) begin
                if (cnt_q == CW'(g)) begin
                    lane_in[l] = data_q[8*(g*LANES+l) +: 8];
                end
            end
            lane_out[l] = SBOX_FWD[lane_in[l]];
`ifdef AES_SBOX_INV_EN
            if (mode_q) begin
                lane_out[l] = SBOX_INV[lane_in[l]];
            end
`endif
        end
    end

    // Merge the substituted lanes back into the active group only.
    always_comb begin
        data_d = data_q;
        for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(i / LANES)) begin
                data_d[8*i +: 8] = lane_out[i % LANES];
            end
        end
    end

    // Control FSM: accept in IDLE, one group per BUSY cycle, hold in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            data_q <= '0;
`ifdef AES_SBOX_INV_EN
            mode_q <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                is_busy: begin
                    data_q <= data_d;
                    if (cnt_q == LAST) begin
                        st_q  <= DONE;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                is_done: begin
                    if (out_ready) begin
                        st_q <= IDLE;
                    end
                end
                default: begin
                    if (in_valid) begin
                        st_q   <= BUSY;
                        cnt_q  <= '0;
                        data_q <= in_data;
`ifdef AES_SBOX_INV_EN
                        mode_q <= in_inv;
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_sub_bytes_engine.sv
// Bench for aes_sub_bytes_engine: S-box model derived from GF(2^8) arithmetic,
// cycle-level handshake model, randomized states and directed corner cases.
module tb_aes_sub_bytes_engine;

    localparam int NBYTES  = 16;
    localparam int LANES   = 4;
    localparam int NGROUPS = NBYTES / LANES;
`ifdef AES_SBOX_INV_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_data = '0;
    logic         in_ready;
    logic         out_valid;
    logic         busy;
    logic [127:0] out_data;

    int total = 0;
    int bad = 0;

    logic [7:0]   sbox_m  [256];
    logic [7:0]   isbox_m [256];
    bit           m_out = 1'b0;
    int           m_age = 0;
    logic [127:0] m_exp = '0;

    aes_sub_bytes_engine #(.NBYTES(NBYTES), .LANES(LANES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(logic [7:0] x, int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] iv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            iv = '0;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
            end
            s = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3)
                ^ rotl(iv, 4) ^ 8'h63;
            sbox_m[x] = s;
            isbox_m[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] expect_state(logic [127:0] d, logic inv);
        logic [127:0] r;
        for (int i = 0; i < NBYTES; i++) begin
            if (inv && INV_EN) r[8*i +: 8] = isbox_m[d[8*i +: 8]];
            else               r[8*i +: 8] = sbox_m[d[8*i +: 8]];
        end
        return r;
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic monitor();
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_out = 1'b0;
            end else if (m_out) begin
                if (m_age >= NGROUPS && out_ready) m_out = 1'b0;
                else m_age++;
            end else if (in_valid) begin
                m_out = 1'b1;
                m_age = 0;
                m_exp = expect_state(in_data, in_inv);
            end
            @(negedge clk);
            chk("in_ready", in_ready, !m_out);
            chk("busy", busy, m_out && m_age < NGROUPS);
            chk("out_valid", out_valid, m_out && m_age >= NGROUPS);
            if (m_out && m_age >= NGROUPS) chk("out_data", out_data, m_exp);
        end
    endtask

    task automatic wait_out(input bit rnd, output logic [127:0] got);
        int n = 0;
        forever begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if ((out_valid && out_ready) || n >= 100) break;
            @(negedge clk);
            n++;
        end
        chk("out_handshake", out_valid, 1'b1);
        got = out_data;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic xfer(input logic [127:0] d, input bit inv, input bit rnd,
                        output logic [127:0] got);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_inv   = 1'($urandom_range(0, 1));
        wait_out(rnd, got);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [127:0] got, f, g, a, b, hold;
        int n;
        build_model();
        chk("sbox_00", sbox_m[8'h00], 8'h63);
        chk("sbox_01", sbox_m[8'h01], 8'h7c);
        chk("sbox_53", sbox_m[8'h53], 8'hed);
        chk("sbox_ff", sbox_m[8'hff], 8'h16);
        chk("isbox_63", isbox_m[8'h63], 8'h00);
        chk("isbox_16", isbox_m[8'h16], 8'hff);
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        rst_n = 1'b1;

        xfer('0, 1'b0, 1'b0, got);
        chk("zero_state", got, {16{8'h63}});
        xfer({4{32'hff530100}}, 1'b0, 1'b0, got);
        chk("byte_order", got, {4{32'h16ed7c63}});

        a = rnd128();
        b = rnd128();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = a;
        in_inv   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_data = b;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        hold = out_data;
        chk("stall_first", hold, expect_state(a, 1'b0));
        repeat (10) begin
            @(negedge clk);
            chk("stall_stable", out_data, hold);
            chk("stall_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_idle", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("stall_second_busy", busy, 1'b1);
        wait_out(1'b0, got);
        chk("stall_second", got, expect_state(b, 1'b0));

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = rnd128();
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        a = rnd128();
        xfer(a, 1'b0, 1'b0, got);
        chk("after_abort", got, expect_state(a, 1'b0));

`ifdef AES_SBOX_INV_EN
        xfer({4{32'h16ed7c63}}, 1'b1, 1'b0, got);
        chk("inverse_known", got, {4{32'hff530100}});
        for (int k = 0; k < 1000; k++) begin
            a = rnd128();
            xfer(a, 1'b0, 1'b1, f);
            xfer(f, 1'b1, 1'b1, g);
            chk("round_trip", g, a);
        end
`else
        xfer('0, 1'b1, 1'b0, got);
        chk("inv_ignored", got, {16{8'h63}});
        for (int k = 0; k < 300; k++) begin
            xfer(rnd128(), 1'($urandom_range(0, 1)), 1'b1, got);
        end
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
